// File: rtl/mac_pkg.sv
// Shared state encoding and Ethernet frame-length limits for the MAC transmit path.
// No logic; imported by the arbiter and its helpers.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    PAD  = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam int ETH_MIN_LEN = 60;
  localparam int ETH_MAX_LEN = 1514;

  // Population count for up to eight per-source flags.
  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set finder: lowest set request at or above the pointer, else wraps to lowest set.
// Purely combinational, zero latency, no backpressure.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // The second pass overrides the wrapped choice whenever a request sits at or above the pointer.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        o_idx   = IDX_W'(j);
        o_found = 1'b1;
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (i_req[j] && (IDX_W'(j) >= i_ptr)) begin
        o_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet round-robin arbiter onto the MAC tx byte port with zero-padding to MIN_LEN and truncation at MAX_LEN.
// Zero-cycle data pass-through; bytes move only when tx_rdy=1, stray and post-truncation bytes are sunk.
module mac_tx_arbiter
  import mac_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN
) (
  input  logic               tx_clk,
  input  logic               rst,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_sop,
  input  logic [N_SRC-1:0]   src_eop,
  input  logic [N_SRC-1:0]   src_valid,
  output logic [N_SRC-1:0]   src_ready,
  output logic [7:0]         tx_data,
  output logic               tx_sop,
  output logic               tx_eop,
  output logic               tx_err,
  output logic               tx_wren,
  input  logic               tx_rdy,
  output logic [15:0]        pkt_count,
  output logic [15:0]        drop_count
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_pick_idx;
  logic [IDX_W-1:0] w_rr_next;
  logic             w_pick_found;
  logic [10:0]      r_byte_cnt;
  logic [15:0]      r_pkt_count;
  logic [15:0]      r_drop_count;

  logic [7:0]       w_src_byte [N_SRC];
  logic [7:0]       w_g_dat;
  logic             w_g_vld;
  logic             w_g_eop;
  logic             w_eop_ok;
  logic             w_at_max;
  logic             w_pad_last;
  logic             w_pkt_done;
  logic             w_trunc;
  logic             w_drop_done;
  logic [N_SRC-1:0] w_stray;
  logic [3:0]       w_stray_cnt;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
    assign w_src_byte[gi] = src_data[8*gi +: 8];
  end

  rr_pick #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (src_valid & src_sop),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_g_dat    = w_src_byte[r_grant];
  assign w_g_vld    = src_valid[r_grant];
  assign w_g_eop    = src_eop[r_grant];
  assign w_eop_ok   = ({1'b0, r_byte_cnt} + 12'd1) >= 12'(MIN_LEN);
  assign w_at_max   = (r_byte_cnt == 11'(MAX_LEN - 1));
  assign w_pad_last = (r_byte_cnt == 11'(MIN_LEN - 1));
  assign w_rr_next  = (r_grant == IDX_W'(N_SRC - 1)) ? '0 : r_grant + 1'b1;

  // tx_wren and src_ready are already held low during reset, so these events are too.
  assign w_stray     = (r_state == IDLE) ? src_ready : '0;
  assign w_stray_cnt = count_ones(8'(w_stray));
  assign w_pkt_done  = tx_wren && (((r_state == PASS) && w_g_eop && w_eop_ok) ||
                                   ((r_state == PAD) && w_pad_last));
  assign w_trunc     = tx_wren && (r_state == PASS) && !w_g_eop && w_at_max;
  assign w_drop_done = !rst && (r_state == DROP) && w_g_vld && w_g_eop;

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_found) w_state_nxt = PASS;
      end
      PASS: begin
        if (tx_wren) begin
          if (w_g_eop) begin
            w_state_nxt = w_eop_ok ? IDLE : PAD;
          end else if (w_at_max) begin
            w_state_nxt = DROP;
          end
        end
      end
      PAD: begin
        if (tx_wren && w_pad_last) w_state_nxt = IDLE;
      end
      DROP: begin
        if (w_g_vld && w_g_eop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    src_ready = '0;
    tx_data   = '0;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    tx_err    = 1'b0;
    tx_wren   = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          src_ready = src_valid & ~src_sop;
        end
        PASS: begin
          src_ready[r_grant] = tx_rdy;
          tx_data = w_g_dat;
          tx_wren = w_g_vld & tx_rdy;
          tx_sop  = w_g_vld & (r_byte_cnt == 11'd0);
          tx_eop  = w_g_vld & ((w_g_eop & w_eop_ok) | (~w_g_eop & w_at_max));
          tx_err  = w_g_vld & ~w_g_eop & w_at_max;
        end
        PAD: begin
          tx_wren = tx_rdy;
          tx_eop  = w_pad_last;
        end
        DROP: begin
          src_ready[r_grant] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The byte count is cleared in IDLE, which every frame passes through before its grant.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_byte_cnt   <= '0;
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if ((r_state == IDLE) && w_pick_found) r_grant <= w_pick_idx;
      if (w_pkt_done || w_drop_done) r_rr_ptr <= w_rr_next;
      if (r_state == IDLE) begin
        r_byte_cnt <= '0;
      end else if (tx_wren) begin
        r_byte_cnt <= r_byte_cnt + 11'd1;
      end
      r_pkt_count  <= r_pkt_count + {15'd0, w_pkt_done};
      r_drop_count <= r_drop_count + {12'd0, w_stray_cnt} + {15'd0, w_trunc};
    end
  end

  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;

endmodule
